stopwatch_timer_dp: RTL and testbench
=====================================

# stopwatch_timer_dp

Parametrised stopwatch/timer datapath. It generates a 1/TICK_HZ time base from clk and maintains an hour:min:sec:centisecond count. The count runs up (stopwatch, with wrap) or down (countdown timer, with terminal stop). It adds preset loading and a lap/freeze display, and it sits between the button-debounce/control FSM and the display formatter. It replaces clock gating with a synchronous run enable, and all time fields update on the same clock edge.

## Interface
Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 100, base tick rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- HOUR_MAX, 24, hour field modulus. HW = $clog2(HOUR_MAX).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  level. 1 = count; 0 = pause.
- clear  in  1  one-cycle pulse. Zeroes the time, prescaler and flags.
- mode  in  1  0 = count up, 1 = count down.
- load  in  1  one-cycle pulse. Loads the preset fields.
- lap  in  1  one-cycle pulse. Toggles display freeze.
- ld_cs  in  7  preset centiseconds.
- ld_sec  in  6  preset seconds.
- ld_min  in  6  preset minutes.
- ld_hour  in  HW  preset hours.
- cs  out  7  displayed centiseconds.
- sec  out  6  displayed seconds.
- min  out  6  displayed minutes.
- hour  out  HW  displayed hours.
- lap_active  out  1  1 = display frozen.
- wrap  out  1  one-cycle pulse when the up-count rolls over from max to zero.
- done  out  1  one-cycle pulse when the down-count reaches zero.
- expired  out  1  sticky; set together with done.

## Operation
- Prescaler: counter 0..DIV-1. It advances only while run=1 and expired=0. It holds its value while paused, so a pause preserves the fractional phase. tick is a combinational signal: prescaler==DIV-1 and counting enabled.
- On tick in up mode, the count increments with a full carry chain. Moduli are 100/60/60/HOUR_MAX.
  - From (HOUR_MAX-1):59:59.99 the count goes to 00:00:00.00 and wrap pulses.
- On tick in down mode, the count decrements with a borrow chain. Borrow sets a field to its modulus-1.
  - When the transition lands on 00:00:00.00: done pulses, expired is set, and counting halts.
  - A tick while the count is already zero in down mode has no effect, with no done pulse.
- expired stays set until clear or load. While expired=1, run is ignored.
- load writes the preset fields into the count. Each preset field is clamped to its modulus-1 (e.g. ld_sec=63 loads 59). load also zeroes the prescaler, clears expired, and releases lap.
- clear sets count=0, prescaler=0, expired=0 and lap_active=0.
- lap with lap_active=0 snapshots the live count into the display registers and sets lap_active. The live count continues running.
  - lap with lap_active=1 releases the freeze, and the outputs track the live count again.
- Outputs = lap_active ? snapshot : live count.
- mode may change at any time. It takes effect on the next tick.
- Same-cycle priority: rst > clear > load > tick. If load or clear coincides with a tick, the tick is discarded.
  - If lap coincides with a tick, the snapshot captures the pre-tick value.
- Internal arithmetic uses field widths exactly. No multi-field binary counter.

## Timing
- Reset values: all time outputs 0, prescaler 0, lap_active 0, wrap 0, done 0, expired 0.
- run rising at edge E: the first count change occurs at edge E+DIV. Subsequent changes occur every DIV cycles.
- All fields update on the same edge as the tick. There is no per-stage ripple latency.
- wrap and done are registered. Each asserts for the single cycle following the edge on which the count changed.
- load, clear and lap take effect on the edge that samples them. Outputs reflect the change in the next cycle.
- Pause for k cycles: the next change is delayed by exactly k cycles.

## Test plan
Run with CLK_HZ=1000, TICK_HZ=100 (DIV=10).
- Reset then run=1, mode=0 for 1000 cycles -> cs=100 mod 100 → sec=1, cs=0. The first change occurs at cycle 10.
- load 23:59:59.99, mode=0, run for 10 cycles -> outputs 00:00:00.00, wrap high for exactly 1 cycle, done=0.
- load 00:00:01.00, mode=1, run -> 00:00:00.99 after 10 cycles.
  - Zero is reached after 1000 cycles total: done pulses once, expired=1.
  - run kept high a further 100 cycles -> outputs stay 0.
- Running up from 0: lap at cycle 55 -> display frozen at cs=5 while live continues. lap at cycle 205 -> display shows cs=20. Release run=0 for 7 cycles mid-interval -> the next increment is delayed 7 cycles.
- load with ld_sec=63, ld_cs=120, ld_hour=HOUR_MAX+3 -> sec=59, cs=99, hour=HOUR_MAX-1.
- clear asserted on the tick edge -> count 0, tick lost. Asynchronous rst mid-count -> all outputs 0 immediately, lap_active=0, expired=0.

Source files
------------

// File: rtl/stopwatch_timer_dp.sv
// Stopwatch/countdown datapath: prescaled tick, hh:mm:ss.cc count with
// preset load, lap freeze, wrap/done pulses and a sticky expired flag.
module stopwatch_timer_dp #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int HOUR_MAX = 24,
  localparam int HW      = $clog2(HOUR_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clear,
  input  logic          mode,
  input  logic          load,
  input  logic          lap,
  input  logic [6:0]    ld_cs,
  input  logic [5:0]    ld_sec,
  input  logic [5:0]    ld_min,
  input  logic [HW-1:0] ld_hour,
  output logic [6:0]    cs,
  output logic [5:0]    sec,
  output logic [5:0]    min,
  output logic [HW-1:0] hour,
  output logic          lap_active,
  output logic          wrap,
  output logic          done,
  output logic          expired
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [HW-1:0] HMAX = HW'(HOUR_MAX - 1);

  typedef struct packed {
    logic [HW-1:0] hour;
    logic [5:0]    min;
    logic [5:0]    sec;
    logic [6:0]    cs;
  } tm_t;

  tm_t           live_q, live_d, snap_q, snap_d, inc, dec, ld_clamp;
  logic [PW-1:0] pre_q, pre_d;
  logic          lap_q, lap_d, exp_q, exp_d, wrap_q, wrap_d, done_q, done_d;
  logic          cnt_en, tick;

  always_comb begin
    cnt_en = run && !exp_q;
    tick   = cnt_en && (pre_q == PW'(DIV - 1));

    ld_clamp.cs   = (ld_cs   > 7'd99) ? 7'd99 : ld_cs;
    ld_clamp.sec  = (ld_sec  > 6'd59) ? 6'd59 : ld_sec;
    ld_clamp.min  = (ld_min  > 6'd59) ? 6'd59 : ld_min;
    ld_clamp.hour = (ld_hour > HMAX)  ? HMAX  : ld_hour;

    // Carry chain: each field rolls only when every lower field rolls.
    inc = live_q;
    if (live_q.cs != 7'd99) inc.cs = live_q.cs + 7'd1;
    else begin
      inc.cs = '0;
      if (live_q.sec != 6'd59) inc.sec = live_q.sec + 6'd1;
      else begin
        inc.sec = '0;
        if (live_q.min != 6'd59) inc.min = live_q.min + 6'd1;
        else begin
          inc.min  = '0;
          inc.hour = (live_q.hour == HMAX) ? '0 : live_q.hour + HW'(1);
        end
      end
    end

    dec = live_q;
    if (live_q.cs != '0) dec.cs = live_q.cs - 7'd1;
    else begin
      dec.cs = 7'd99;
      if (live_q.sec != '0) dec.sec = live_q.sec - 6'd1;
      else begin
        dec.sec = 6'd59;
        if (live_q.min != '0) dec.min = live_q.min - 6'd1;
        else begin
          dec.min  = 6'd59;
          dec.hour = (live_q.hour == '0) ? HMAX : live_q.hour - HW'(1);
        end
      end
    end

    live_d = live_q;
    snap_d = snap_q;
    pre_d  = pre_q;
    lap_d  = lap_q;
    exp_d  = exp_q;
    wrap_d = 1'b0;
    done_d = 1'b0;

    if (cnt_en) pre_d = tick ? '0 : pre_q + PW'(1);
    // Snapshot takes live_q, i.e. the value before any same-edge tick.
    if (lap) begin
      if (!lap_q) snap_d = live_q;
      lap_d = !lap_q;
    end

    if (clear) begin
      live_d = '0;
      pre_d  = '0;
      exp_d  = 1'b0;
      lap_d  = 1'b0;
    end else if (load) begin
      live_d = ld_clamp;
      pre_d  = '0;
      exp_d  = 1'b0;
      lap_d  = 1'b0;
    end else if (tick) begin
      if (!mode) begin
        live_d = inc;
        wrap_d = (inc == '0);
      end else if (live_q != '0) begin
        live_d = dec;
        if (dec == '0) begin
          done_d = 1'b1;
          exp_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= '0;
      snap_q <= '0;
      pre_q  <= '0;
      lap_q  <= 1'b0;
      exp_q  <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      live_q <= live_d;
      snap_q <= snap_d;
      pre_q  <= pre_d;
      lap_q  <= lap_d;
      exp_q  <= exp_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign cs         = lap_q ? snap_q.cs   : live_q.cs;
  assign sec        = lap_q ? snap_q.sec  : live_q.sec;
  assign min        = lap_q ? snap_q.min  : live_q.min;
  assign hour       = lap_q ? snap_q.hour : live_q.hour;
  assign lap_active = lap_q;
  assign wrap       = wrap_q;
  assign done       = done_q;
  assign expired    = exp_q;
endmodule

// File: tb/tb_stopwatch_timer_dp.sv
// Bench for stopwatch_timer_dp: directed vector table, reset corner case and
// randomized traffic checked against a total-centisecond reference model.
module tb_stopwatch_timer_dp;
  localparam int CLK_HZ = 1000, TICK_HZ = 100, HOUR_MAX = 24;
  localparam int HW = $clog2(HOUR_MAX);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DAY = HOUR_MAX * 360000;

  typedef logic [HW+22:0] ov_t;

  logic clk, rst, run, clear, mode, load, lap;
  logic [6:0] ld_cs, cs;
  logic [5:0] ld_sec, ld_min, sec, min;
  logic [HW-1:0] ld_hour, hour;
  logic lap_active, wrap, done, expired;

  stopwatch_timer_dp #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MAX(HOUR_MAX)) dut (
    .clk(clk), .rst(rst), .run(run), .clear(clear), .mode(mode), .load(load), .lap(lap),
    .ld_cs(ld_cs), .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
    .cs(cs), .sec(sec), .min(min), .hour(hour), .lap_active(lap_active),
    .wrap(wrap), .done(done), .expired(expired));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  // Reference model: the whole time as one centisecond count plus a phase.
  int m_tot, m_ph, m_snap;
  logic m_exp, m_lap, m_wrap, m_done;

  typedef struct {
    logic r, md, c, l, p;
    int h, mi, s, cc, n;
    int eh, em, es, ec;
    logic ela, ewr, edn, eex;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, md, c, l, p, input int h, mi, s, cc, n,
                              input int eh, em, es, ec, input logic ela, ewr, edn, eex);
    vec_t v;
    v.r = r; v.md = md; v.c = c; v.l = l; v.p = p;
    v.h = h; v.mi = mi; v.s = s; v.cc = cc; v.n = n;
    v.eh = eh; v.em = em; v.es = es; v.ec = ec;
    v.ela = ela; v.ewr = ewr; v.edn = edn; v.eex = eex;
    return v;
  endfunction

  function automatic ov_t fmt(input int t, input logic la, wr, dn, ex);
    return {HW'(t / 360000), 6'((t / 6000) % 60), 6'((t / 100) % 60), 7'(t % 100), la, wr, dn, ex};
  endfunction

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic ov_t dut_ov();
    return {hour, min, sec, cs, lap_active, wrap, done, expired};
  endfunction

  task automatic check(input string name, input ov_t act, input ov_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tot = 0; m_ph = 0; m_snap = 0;
    m_exp = 1'b0; m_lap = 1'b0; m_wrap = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic r, md, c, l, p, input int h, mi, s, cc);
    logic en, tk;
    en = r && !m_exp;
    tk = en && (m_ph == DIV - 1);
    m_wrap = 1'b0;
    m_done = 1'b0;
    if (en) m_ph = tk ? 0 : m_ph + 1;
    if (p) begin
      if (!m_lap) m_snap = m_tot;
      m_lap = !m_lap;
    end
    if (c) begin
      m_tot = 0; m_ph = 0; m_exp = 1'b0; m_lap = 1'b0;
    end else if (l) begin
      m_tot = ((clampi(h, HOUR_MAX - 1) * 60 + clampi(mi, 59)) * 60 + clampi(s, 59)) * 100
              + clampi(cc, 99);
      m_ph = 0; m_exp = 1'b0; m_lap = 1'b0;
    end else if (tk) begin
      if (!md) begin
        m_tot = (m_tot + 1) % DAY;
        m_wrap = (m_tot == 0);
      end else if (m_tot > 0) begin
        m_tot--;
        if (m_tot == 0) begin
          m_done = 1'b1;
          m_exp = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive, let the edge happen, advance model, compare.
  task automatic cyc(input logic r, md, c, l, p, input int h, mi, s, cc);
    run = r; mode = md; clear = c; load = l; lap = p;
    ld_hour = HW'(h); ld_min = 6'(mi); ld_sec = 6'(s); ld_cs = 7'(cc);
    @(posedge clk);
    model_step(r, md, c, l, p, h, mi, s, cc);
    #1;
    check("model", dut_ov(), fmt(m_lap ? m_snap : m_tot, m_lap, m_wrap, m_done, m_exp));
  endtask

  initial begin
    //            r  md c  l  p  h   mi s   cc   n    eh em es ec  la wr dn ex
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   9,   0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   1,   0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   990, 0, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 23, 59, 59, 99, 1,   23, 59, 59, 99, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   10,  0, 0, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   1,   0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0,  0, 1,  0,   1,   0, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0,  0,   10,  0, 0, 0, 99, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0,  0,   989, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0,  0,   1,   0, 0, 0,  0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0,  0,   1,   0, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0,  0,   100, 0, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 27, 5, 63, 120, 1,   23, 5, 59, 99, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0,  0,   1,   0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   54,  0, 0, 0,  5, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0,  0, 0,  0,   1,   0, 0, 0,  5, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   100, 0, 0, 0,  5, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   49,  0, 0, 0,  5, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0,  0, 0,  0,   1,   0, 0, 0, 20, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   2,   0, 0, 0, 20, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0,   7,   0, 0, 0, 20, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   2,   0, 0, 0, 20, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   1,   0, 0, 0, 21, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   9,   0, 0, 0, 21, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0,  0, 0,  0,   1,   0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   9,   0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0,   1,   0, 0, 0,  1, 0, 0, 0, 0));

    rst = 1'b1; run = 0; clear = 0; mode = 0; load = 0; lap = 0;
    ld_cs = '0; ld_sec = '0; ld_min = '0; ld_hour = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_ov(), '0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      for (int i = 0; i < tbl[k].n; i++)
        cyc(tbl[k].r, tbl[k].md, (i == 0) && tbl[k].c, (i == 0) && tbl[k].l, (i == 0) && tbl[k].p,
            tbl[k].h, tbl[k].mi, tbl[k].s, tbl[k].cc);
      check($sformatf("vec%0d", k), dut_ov(),
            {HW'(tbl[k].eh), 6'(tbl[k].em), 6'(tbl[k].es), 7'(tbl[k].ec),
             tbl[k].ela, tbl[k].ewr, tbl[k].edn, tbl[k].eex});
    end

    // Asynchronous reset while frozen and counting: outputs clear before any edge.
    for (int i = 0; i < 37; i++) cyc(1, 0, 0, 0, i == 30, 0, 0, 0, 0);
    check("pre_rst_lap", {lap_active, expired}, {1'b1, 1'b0});
    #2 rst = 1'b1;
    #1 check("async_rst", dut_ov(), '0);
    #2 rst = 1'b0;
    model_reset();

    begin
      logic r, md, c, l, p;
      int h, mi, s, cc;
      md = 1'b0;
      h = 0; mi = 0; s = 0; cc = 0;
      for (int i = 0; i < 5000; i++) begin
        r = ($urandom % 8) != 0;
        if ($urandom % 300 == 0) md = ~md;
        c = ($urandom % 500) == 0;
        l = ($urandom % 350) == 0;
        p = ($urandom % 60) == 0;
        if (l) begin
          md = $urandom % 2;
          case ($urandom % 3)
            0: begin h = 23; mi = 59; s = 59; cc = 90 + $urandom % 10; md = 1'b0; end
            1: begin h = 0; mi = 0; s = 0; cc = $urandom % 64; md = 1'b1; end
            default: begin h = $urandom % 32; mi = $urandom % 64; s = $urandom % 64; cc = $urandom % 128; end
          endcase
        end
        cyc(r, md, c, l, p, h, mi, s, cc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
